// File: rtl/chasm_mem_seq.sv
// Multi-cycle memory access sequencer: runs one read/write handshake per request,
// then pulses done (and ld_mdr for reads). A wait counter traps a memory that never answers.
module chasm_mem_seq #(
  parameter int width   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_read,
  input  logic             req_write,
  input  logic [width-1:0] addr,
  input  logic [width-1:0] wdata,
  input  logic             err_clear,
  input  logic             mem_resp,
  input  logic [width-1:0] mem_rdata,
  output logic             mem_read,
  output logic             mem_write,
  output logic [width-1:0] mem_address,
  output logic [width-1:0] mem_wdata,
  output logic             ld_mdr,
  output logic [width-1:0] mdr_in,
  output logic             done,
  output logic             busy,
  output logic             timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  // Last counter value before the watchdog fires (counter starts at 0 on entry).
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [width-1:0]   addr_q, addr_d;
  logic [width-1:0]   wdata_q, wdata_d;
  logic [width-1:0]   rdata_q, rdata_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               rd_q, rd_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= 16'd0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    case (state_q)
      S_IDLE: begin
        // Read has priority; a simultaneous write is simply dropped.
        if (req_read) begin
          addr_d  = addr;
          rd_d    = 1'b1;
          cnt_d   = 16'd0;
          state_d = S_READ;
        end else if (req_write) begin
          addr_d  = addr;
          wdata_d = wdata;
          rd_d    = 1'b0;
          cnt_d   = 16'd0;
          state_d = S_WRITE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ, S_WRITE: begin
        if (mem_resp) begin
          if (state_q == S_READ) begin
            rdata_d = mem_rdata;
          end else begin
            rdata_d = rdata_q;
          end
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERR: begin
        if (err_clear) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ERR;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode only flopped state/data, so no input reaches an output combinationally.
  assign mem_read    = (state_q == S_READ);
  assign mem_write   = (state_q == S_WRITE);
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;
  assign done        = (state_q == S_DONE);
  assign ld_mdr      = (state_q == S_DONE) && rd_q;
  assign mdr_in      = rdata_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = (state_q == S_ERR);

endmodule

// File: tb/tb_chasm_mem_seq.sv
// Self-checking bench for chasm_mem_seq: directed scenarios plus random transactions
// checked against a transaction-level model of strobe length, completion and timeout.
module tb_chasm_mem_seq;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_read, req_write, err_clear, mem_resp;
  logic [15:0] addr, wdata, mem_rdata;
  logic        mem_read, mem_write, ld_mdr, done, busy, timeout_err;
  logic [15:0] mem_address, mem_wdata, mdr_in;

  int          total = 0;
  int          bad = 0;
  logic [15:0] model_mdr = 16'h0000;

  chasm_mem_seq #(.width(16), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_read(req_read), .req_write(req_write),
    .addr(addr), .wdata(wdata), .err_clear(err_clear), .mem_resp(mem_resp),
    .mem_rdata(mem_rdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .ld_mdr(ld_mdr),
    .mdr_in(mdr_in), .done(done), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_rd"}, mem_read, 1'b0);
    chk1({tag, "_wr"}, mem_write, 1'b0);
    chk16({tag, "_addr"}, mem_address, 16'h0000);
    chk16({tag, "_wdata"}, mem_wdata, 16'h0000);
    chk1({tag, "_ld"}, ld_mdr, 1'b0);
    chk16({tag, "_mdr"}, mdr_in, 16'h0000);
    chk1({tag, "_done"}, done, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_err"}, timeout_err, 1'b0);
  endtask

  // Present a request in an idle cycle; the DUT samples it at the next edge.
  task automatic issue(input bit is_rd, input bit both, input logic [15:0] a,
                       input logic [15:0] wd, input bit keep);
    chk1("idle_busy", busy, 1'b0);
    req_read  = is_rd;
    req_write = !is_rd || both;
    addr      = a;
    wdata     = wd;
    step();
    if (!keep) begin
      req_read  = 1'b0;
      req_write = 1'b0;
      addr      = 16'($urandom);
      wdata     = 16'($urandom);
    end
  endtask

  // Expected behaviour: memory answers in strobe cycle lat; lat > TO never answers.
  task automatic run(input bit is_rd, input logic [15:0] a, input logic [15:0] wd,
                     input logic [15:0] rd, input int lat);
    int n;
    n = (lat <= TO) ? lat : TO;
    for (int c = 1; c <= n; c++) begin
      chk1("strobe_rd", mem_read, is_rd);
      chk1("strobe_wr", mem_write, !is_rd);
      chk16("address", mem_address, a);
      chk1("busy_acc", busy, 1'b1);
      chk1("done_low", done, 1'b0);
      if (!is_rd) chk16("wdata", mem_wdata, wd);
      if (c == lat) begin
        mem_resp  = 1'b1;
        mem_rdata = rd;
      end
      step();
      mem_resp  = 1'b0;
      mem_rdata = 16'($urandom);
    end
    if (lat <= TO) begin
      if (is_rd) model_mdr = rd;
      chk1("done_pulse", done, 1'b1);
      chk1("ld_mdr", ld_mdr, is_rd);
      chk16("mdr_in", mdr_in, model_mdr);
      chk1("done_rd", mem_read, 1'b0);
      chk1("done_wr", mem_write, 1'b0);
      chk1("done_busy", busy, 1'b1);
      mem_resp = 1'($urandom_range(0, 1));
      step();
      mem_resp = 1'b0;
      chk1("post_done", done, 1'b0);
      chk1("post_ld", ld_mdr, 1'b0);
      chk1("post_busy", busy, 1'b0);
      chk16("post_mdr", mdr_in, model_mdr);
    end else begin
      chk1("err_flag", timeout_err, 1'b1);
      chk1("err_busy", busy, 1'b1);
      chk1("err_rd", mem_read, 1'b0);
      chk1("err_wr", mem_write, 1'b0);
      chk1("err_done", done, 1'b0);
      mem_resp = 1'b1;
      step();
      mem_resp = 1'b0;
      chk1("err_hold", timeout_err, 1'b1);
      chk1("err_late_done", done, 1'b0);
      chk16("err_mdr", mdr_in, model_mdr);
      err_clear = 1'b1;
      step();
      err_clear = 1'b0;
      chk1("clr_err", timeout_err, 1'b0);
      chk1("clr_busy", busy, 1'b0);
      chk1("clr_done", done, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    reset = 1'b1; req_read = 1'b0; req_write = 1'b0; err_clear = 1'b0;
    mem_resp = 1'b0; addr = 16'h0000; wdata = 16'h0000; mem_rdata = 16'h0000;
    step();
    chk_all_zero("rst_held");
    @(negedge clk);
    reset = 1'b0;
    step();
    chk_all_zero("rst_rel");

    // 3-cycle read
    issue(1'b1, 1'b0, 16'h3000, 16'h0000, 1'b0);
    run(1'b1, 16'h3000, 16'h0000, 16'hBEEF, 3);

    // write with immediate response, mdr_in untouched
    issue(1'b0, 1'b0, 16'h4010, 16'h1234, 1'b0);
    run(1'b0, 16'h4010, 16'h1234, 16'h0000, 1);

    // simultaneous requests: read wins
    issue(1'b1, 1'b1, 16'h0005, 16'h5555, 1'b0);
    run(1'b1, 16'h0005, 16'h0000, 16'hC0DE, 2);

    // watchdog
    issue(1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0);
    run(1'b1, 16'h0100, 16'h0000, 16'h0000, TO + 1);

    // reset during 2nd cycle of a read
    issue(1'b1, 1'b0, 16'h0777, 16'h0000, 1'b0);
    chk1("pre_rst_c1", mem_read, 1'b1);
    step();
    chk1("pre_rst_c2", mem_read, 1'b1);
    #2 reset = 1'b1;
    #1 chk_all_zero("mid_rst");
    model_mdr = 16'h0000;
    @(negedge clk);
    reset = 1'b0;
    step();
    chk_all_zero("mid_rst_rel");
    issue(1'b1, 1'b0, 16'h0888, 16'h0000, 1'b0);
    run(1'b1, 16'h0888, 16'h0000, 16'h7777, 2);

    // back-to-back reads with the request held high
    issue(1'b1, 1'b0, 16'h0001, 16'h0000, 1'b1);
    addr = 16'h0002;
    run(1'b1, 16'h0001, 16'h0000, 16'h00AA, 2);
    step();
    req_read = 1'b0;
    run(1'b1, 16'h0002, 16'h0000, 16'h00BB, 1);

    // random traffic
    for (int i = 0; i < 40; i++) begin
      bit          is_rd, both;
      int          lat;
      logic [15:0] a, wd, rd;
      is_rd = 1'($urandom_range(0, 1));
      both  = is_rd && (1'($urandom_range(0, 1)) == 1'b1);
      lat   = int'($urandom_range(1, TO + 2));
      a     = 16'($urandom);
      wd    = 16'($urandom);
      rd    = 16'($urandom);
      issue(is_rd, both, a, wd, 1'b0);
      run(is_rd, a, wd, rd, lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
